cam_array: RTL and testbench

- Multi-entry, parametrised content-addressable memory.
- Each entry holds a key, an associated data word and a valid bit. A search compares the key against all valid entries in parallel and returns the lowest-index hit plus its data.
- Successor to the single-entry combinational CAM: adds depth, write/invalidate ports, a registered 2-stage search pipeline and a flush.
- Sits in front of lookup tables in the datapath, e.g. tag match or ID-to-payload translation.

---
 rtl/cam_array.sv | 117 +++++++++++
 tb/tb_cam_array.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_array.sv
// Parametrised CAM: valid/key/data entries, 2-stage registered search, flush.
// Optional CAM_MULTI_HIT_EN adds multi_hit and hit_vec outputs.
module cam_array #(
  parameter int KEY_W  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inv_en,
  input  logic [ADDR_W-1:0] inv_addr,
  input  logic              flush,
  input  logic              srch_valid,
  input  logic [KEY_W-1:0]  srch_key,
  output logic              rslt_valid,
  output logic              hit,
  output logic [ADDR_W-1:0] hit_addr,
  output logic [DATA_W-1:0] hit_data,
`ifdef CAM_MULTI_HIT_EN
  output logic              multi_hit,
  output logic [DEPTH-1:0]  hit_vec,
`endif
  output logic [ADDR_W:0]   occupancy
);

  logic [KEY_W-1:0]  keys [DEPTH];
  logic [DATA_W-1:0] datas [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  valid_n;
  logic [DEPTH-1:0]  match;
  logic [DEPTH-1:0]  s1_match;
  logic              s1_valid;
  logic [ADDR_W-1:0] enc;
  logic [ADDR_W:0]   cnt;

  // write beats invalidate on the same entry; flush beats both
  always_comb begin
    valid_n = valid;
    if (inv_en) valid_n[inv_addr] = 1'b0;
    if (wr_en) valid_n[wr_addr] = 1'b1;
    if (flush) valid_n = '0;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt = cnt + (ADDR_W+1)'(valid_n[i]);
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = valid[i] && (keys[i] == srch_key);
  end

  always_comb begin
    enc = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (s1_match[i]) enc = ADDR_W'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        keys[i]  <= '0;
        datas[i] <= '0;
      end
    end else begin
      valid     <= valid_n;
      occupancy <= cnt;
      if (wr_en && !flush) begin
        keys[wr_addr]  <= wr_key;
        datas[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_match   <= '0;
      rslt_valid <= 1'b0;
      hit        <= 1'b0;
      hit_addr   <= '0;
      hit_data   <= '0;
    end else begin
      s1_valid   <= srch_valid;
      s1_match   <= match;
      rslt_valid <= s1_valid;
      if (s1_valid) begin
        hit      <= |s1_match;
        hit_addr <= enc;
        hit_data <= (|s1_match) ? datas[enc] : '0;
      end
    end
  end

`ifdef CAM_MULTI_HIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      multi_hit <= 1'b0;
      hit_vec   <= '0;
    end else if (s1_valid) begin
      multi_hit <= |(s1_match & (s1_match - 1'b1));
      hit_vec   <= s1_match;
    end
  end
`endif

endmodule

// File: tb/tb_cam_array.sv
// Directed self-checking bench for cam_array.
// Expected values are hand-computed per step.
module tb_cam_array;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_key;
  logic [7:0] wr_data;
  logic       inv_en;
  logic [2:0] inv_addr;
  logic       flush;
  logic       srch_valid;
  logic [3:0] srch_key;
  logic       rslt_valid;
  logic       hit;
  logic [2:0] hit_addr;
  logic [7:0] hit_data;
  logic [3:0] occupancy;
`ifdef CAM_MULTI_HIT_EN
  logic       multi_hit;
  logic [7:0] hit_vec;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cam_array dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_key(wr_key), .wr_data(wr_data),
    .inv_en(inv_en), .inv_addr(inv_addr),
    .flush(flush),
    .srch_valid(srch_valid), .srch_key(srch_key),
    .rslt_valid(rslt_valid), .hit(hit),
    .hit_addr(hit_addr), .hit_data(hit_data),
`ifdef CAM_MULTI_HIT_EN
    .multi_hit(multi_hit), .hit_vec(hit_vec),
`endif
    .occupancy(occupancy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [3:0] k,
                    input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_key = k; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic srch(input logic [3:0] k);
    srch_valid = 1'b1; srch_key = k;
    tick();
    srch_valid = 1'b0;
    tick();
  endtask

  task automatic res(input string tag, input logic h,
                     input logic [2:0] a, input logic [7:0] d);
    chk({tag, "_rv"}, 32'(rslt_valid), 32'd1);
    chk({tag, "_hit"}, 32'(hit), 32'(h));
    chk({tag, "_addr"}, 32'(hit_addr), 32'(a));
    chk({tag, "_data"}, 32'(hit_data), 32'(d));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_key = '0;
    wr_data = '0; inv_en = 1'b0; inv_addr = '0; flush = 1'b0;
    srch_valid = 1'b0; srch_key = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rv", 32'(rslt_valid), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_addr", 32'(hit_addr), 32'd0);
    chk("rst_data", 32'(hit_data), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
`ifdef CAM_MULTI_HIT_EN
    chk("rst_mh", 32'(multi_hit), 32'd0);
    chk("rst_hv", 32'(hit_vec), 32'd0);
`endif

    // empty search: result exactly two edges later
    srch_valid = 1'b1; srch_key = 4'h5;
    tick();
    srch_valid = 1'b0;
    chk("empty_lat1", 32'(rslt_valid), 32'd0);
    tick();
    res("empty", 1'b0, 3'd0, 8'h00);
    chk("empty_occ", 32'(occupancy), 32'd0);
    tick();
    chk("empty_rv_drop", 32'(rslt_valid), 32'd0);

    wr(3'd3, 4'hA, 8'h3C);
    tick();
    chk("occ1", 32'(occupancy), 32'd1);
    srch(4'hA);
    res("a3", 1'b1, 3'd3, 8'h3C);
    tick();
    chk("hold_rv", 32'(rslt_valid), 32'd0);
    chk("hold_hit", 32'(hit), 32'd1);
    chk("hold_addr", 32'(hit_addr), 32'd3);
    chk("hold_data", 32'(hit_data), 32'h3C);

    wr(3'd2, 4'h7, 8'h11);
    wr(3'd6, 4'h7, 8'h66);
    srch(4'h7);
    res("dup7", 1'b1, 3'd2, 8'h11);
    chk("occ3", 32'(occupancy), 32'd3);
`ifdef CAM_MULTI_HIT_EN
    chk("dup7_mh", 32'(multi_hit), 32'd1);
    chk("dup7_hv", 32'(hit_vec), 32'h44);
`endif

    // search sees contents before the same-cycle write
    srch_valid = 1'b1; srch_key = 4'hA;
    wr_en = 1'b1; wr_addr = 3'd0; wr_key = 4'hA; wr_data = 8'h55;
    tick();
    srch_valid = 1'b0; wr_en = 1'b0;
    tick();
    res("rbw_old", 1'b1, 3'd3, 8'h3C);
    srch(4'hA);
    res("rbw_new", 1'b1, 3'd0, 8'h55);
    chk("occ4", 32'(occupancy), 32'd4);

    inv_en = 1'b1; inv_addr = 3'd0;
    tick();
    inv_en = 1'b0;
    tick();
    chk("inv_occ", 32'(occupancy), 32'd3);
    inv_en = 1'b1; inv_addr = 3'd0;
    tick();
    inv_en = 1'b0;
    tick();
    chk("inv_noop_occ", 32'(occupancy), 32'd3);

    // back-to-back searches
    srch_valid = 1'b1; srch_key = 4'hA;
    tick();
    srch_key = 4'h7;
    tick();
    srch_key = 4'hF;
    res("b2b_a", 1'b1, 3'd3, 8'h3C);
    tick();
    srch_valid = 1'b0;
    res("b2b_7", 1'b1, 3'd2, 8'h11);
`ifdef CAM_MULTI_HIT_EN
    chk("b2b_7_mh", 32'(multi_hit), 32'd1);
`endif
    tick();
    res("b2b_f", 1'b0, 3'd0, 8'h00);
`ifdef CAM_MULTI_HIT_EN
    chk("b2b_f_mh", 32'(multi_hit), 32'd0);
    chk("b2b_f_hv", 32'(hit_vec), 32'd0);
`endif
    tick();
    chk("b2b_end", 32'(rslt_valid), 32'd0);

    // write and invalidate same entry: write wins
    wr_en = 1'b1; wr_addr = 3'd5; wr_key = 4'h9; wr_data = 8'h99;
    inv_en = 1'b1; inv_addr = 3'd5;
    tick();
    wr_en = 1'b0; inv_en = 1'b0;
    srch(4'h9);
    res("winv", 1'b1, 3'd5, 8'h99);
    chk("winv_occ", 32'(occupancy), 32'd4);

    // flush overrides a same-cycle write
    flush = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd1; wr_key = 4'hB; wr_data = 8'hBB;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    tick();
    chk("flush_occ", 32'(occupancy), 32'd0);
    srch(4'hB);
    res("flush_b", 1'b0, 3'd0, 8'h00);
    srch(4'h7);
    res("flush_7", 1'b0, 3'd0, 8'h00);

    // reset kills a search sitting in stage 1
    wr(3'd4, 4'h3, 8'h44);
    srch_valid = 1'b1; srch_key = 4'h3;
    tick();
    srch_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_kill_rv0", 32'(rslt_valid), 32'd0);
    tick();
    chk("rst_kill_rv1", 32'(rslt_valid), 32'd0);
    chk("rst_kill_occ", 32'(occupancy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
